// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction-memory loader
//
// Purpose: state encodings for the loader FSM and the UART receiver, plus the
// length-field size of the boot stream.
package loader_pkg;

  typedef enum logic [1:0] {
    WAIT_LEN,
    DATA,
    RUN
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Bytes in the little-endian word-count header (and in every data word).
  localparam int LEN_BYTES = 4;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with start-bit glitch rejection
//
// Purpose: synchronizes the serial line, samples each bit at its centre and
// presents one byte per valid frame.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   i_rx            - serial input, idle high, asynchronous to clk
//   o_byte_valid    - one-cycle pulse, cycle after the stop-bit sample
//   o_byte_data     - received byte, valid with o_byte_valid
//   o_stop_err      - one-cycle pulse when the stop bit was sampled low
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  rx_state_t     r_state, w_next;
  logic          r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_valid, r_stop_err;
  logic          w_cnt_full, w_half;

  assign w_cnt_full = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_half     = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:      if (r_prev && !r_sync2) w_next = RX_START;
      RX_START:     if (w_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (w_cnt_full && r_bit == 3'd7) w_next = RX_STOP;
      RX_STOP:      if (w_cnt_full) w_next = r_sync2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (r_sync2) w_next = RX_IDLE;
      default:      w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b1;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_sync1      <= i_rx;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_state)
        // The edge-detect cycle counts as the first cycle of the start bit,
        // pulling the sample points back toward the bit centres despite the
        // synchronizer latency.
        RX_IDLE: r_cnt <= CW'(1);
        RX_START: begin
          if (w_half) begin
            r_cnt <= '0;
            r_bit <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_cnt_full) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};  // LSB arrives first
            r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_cnt_full) begin
            r_cnt <= '0;
            if (r_sync2) r_byte_valid <= 1'b1;
            else         r_stop_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_shift;
  assign o_stop_err   = r_stop_err;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader and async-read instruction RAM
//
// Purpose: receives a length-prefixed program over UART, writes it into the
// instruction RAM, holds the core in reset until done, then serves instr[pc].
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   uart_rx         - serial input, 8N1
//   pc / instr      - core byte address in, combinational instruction out
//   core_reset      - high until loading completes
//   loading         - high in WAIT_LEN and DATA
//   frame_err       - sticky bad-stop-bit flag
//   words_loaded    - words written into RAM, saturating at DEPTH
module imem_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 1024,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rx,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          core_reset,
  output logic          loading,
  output logic          frame_err,
  output logic [AW:0]   words_loaded
);

  localparam logic [1:0] LANE_LAST = 2'(LEN_BYTES - 1);

  loader_state_t r_state, w_next;
  logic [1:0]    r_lane;
  logic [23:0]   r_asm;
  logic [31:0]   r_len, r_index;
  logic [AW:0]   r_words;
  logic          r_core_reset, r_loading, r_frame_err;
  logic [31:0]   ram [DEPTH];

  logic          w_byte_valid, w_stop_err;
  logic [7:0]    w_byte_data;
  logic          w_word_done, w_in_range, w_write;
  logic [31:0]   w_word;
  logic          w_unused;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (uart_rx),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_stop_err  (w_stop_err)
  );

  assign w_word      = {w_byte_data, r_asm};
  assign w_word_done = w_byte_valid && (r_lane == LANE_LAST) && (r_state != RUN);
  assign w_in_range  = (r_index < 32'(DEPTH));
  assign w_write     = w_word_done && (r_state == DATA) && w_in_range;

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_LEN: if (w_word_done) w_next = (w_word == 32'd0) ? RUN : DATA;
      DATA:     if (w_word_done && (r_index + 32'd1 == r_len)) w_next = RUN;
      RUN:      w_next = RUN;
      default:  w_next = WAIT_LEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_LEN;
      r_lane       <= '0;
      r_asm        <= '0;
      r_len        <= '0;
      r_index      <= '0;
      r_words      <= '0;
      r_core_reset <= 1'b1;
      r_loading    <= 1'b1;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_core_reset <= (w_next != RUN);
      r_loading    <= (w_next != RUN);
      if (w_stop_err) r_frame_err <= 1'b1;
      if (w_byte_valid && r_state != RUN) begin
        r_lane <= (w_next != r_state) ? 2'd0 : r_lane + 2'd1;
        // After three bytes r_asm holds {b2, b1, b0}; the 4th completes w_word.
        r_asm  <= {w_byte_data, r_asm[23:8]};
      end
      if (w_word_done && r_state == WAIT_LEN) begin
        r_len   <= w_word;
        r_index <= '0;
      end
      if (w_word_done && r_state == DATA) begin
        r_index <= r_index + 32'd1;
        if (w_in_range) r_words <= r_words + 1'b1;
      end
    end
  end

  // No reset: contents survive a reset issued mid-load.
  always_ff @(posedge clk) begin
    if (w_write) ram[r_index[AW-1:0]] <= w_word;
  end

  assign instr        = ram[pc[AW+1:2]];
  assign w_unused     = ^{pc[31:AW+2], pc[1:0]};
  assign core_reset   = r_core_reset;
  assign loading      = r_loading;
  assign frame_err    = r_frame_err;
  assign words_loaded = r_words;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the pipelined core's fetch stage. It receives a program over a UART serial line, writes it word by word into an on-chip instruction RAM, and holds the core in reset until loading finishes. It then serves instructions combinationally to the core's `instr` input from the core's `pc`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `DEPTH`, default 1024: instruction RAM size in 32-bit words; power of two.
- `AW`, default `$clog2(DEPTH)`: word-address width.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `uart_rx`  in  1: serial input, 8N1, idle high, asynchronous to `clk`.
- `pc`  in  32: core program counter (byte address).
- `instr`  out  32: instruction word at `pc`, driven to the core's `instr`.
- `core_reset`  out  1: drives the core's `reset`; high while loading.
- `loading`  out  1: high in WAIT_LEN and DATA states.
- `frame_err`  out  1: sticky; set when a byte has a bad stop bit.
- `words_loaded`  out  AW+1: number of words written so far.

## Operation
- **UART receiver**
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge while idle starts a frame.
  - The start bit is re-checked at `CLKS_PER_BIT/2`. If the line is high there, the receiver returns to idle (glitch rejected).
  - The 8 data bits are sampled LSB-first at the centre of each bit.
  - The stop bit is sampled at its centre.
    - Stop bit = 1: `byte_valid` pulses for one cycle with `byte_data`.
    - Stop bit = 0: the byte is dropped, `frame_err` is set, and the receiver waits for the line to go high before re-arming.
- **Stream format**
  - 4-byte little-endian word count N, then N instruction words, each 4 bytes little-endian.
- **Loader FSM** (states WAIT_LEN, DATA, RUN)
  - WAIT_LEN: assemble 4 bytes into N. On the 4th byte:
    - N == 0 → RUN.
    - Otherwise → DATA, with word index 0.
  - DATA: assemble 4 bytes. On the 4th byte:
    - If index < DEPTH, write `ram[index]` and increment `words_loaded`.
    - Increment index.
    - If index+1 == N → RUN.
    - Words with index ≥ DEPTH are consumed but not written; `words_loaded` saturates at DEPTH.
  - RUN: terminal until `reset`. Further UART bytes are received and ignored.
  - A byte lane counter (0..3) resets to 0 on every state change.
- **Read port**
  - `instr = ram[pc[AW+1:2]]`, combinational.
  - `pc[1:0]` and bits above AW+1 are ignored, so addresses wrap modulo DEPTH words.
- **Reset**
  - Returns the FSM to WAIT_LEN and the UART receiver to idle.
  - Clears the counters and `frame_err`.
  - Forces `core_reset` = 1.
  - RAM contents are not reset and are retained across a reset issued mid-load.

## Timing
- Reset values: `core_reset` = 1, `loading` = 1, `frame_err` = 0, `words_loaded` = 0.
- `instr` is combinational, with no reset value: it is whatever the RAM holds.
- `byte_valid` fires in the cycle after the stop-bit centre sample.
- A RAM write occurs on the edge where `byte_valid` is high and the lane counter = 3.
- `core_reset` and `loading` are registered and go low on the same edge as the final write, or as the 4th length byte when N = 0.
- The core's first fetch sees the final word already in RAM. There is no read/write overlap because the core is held in reset throughout loading.
- One byte takes 10×`CLKS_PER_BIT` cycles, ±½ bit of sampling tolerance.
- A frame_err byte does not advance the lane counter. Subsequent bytes are misaligned; recovery is by `reset`.

## Structure
- **Shared package `loader_pkg`**:
  - enum `loader_state_t` {WAIT_LEN, DATA, RUN};
  - UART state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH};
  - constant `LEN_BYTES` = 4.
- **Sub-module `uart_rx`**, parameterised by `CLKS_PER_BIT`: synchronizer, bit counter, baud counter; outputs `byte_valid`, `byte_data`, `stop_err`.
- **Top level**: loader FSM, byte assembler, RAM (inferred distributed/block RAM with async read).

## Test plan
Use `CLKS_PER_BIT`=4 and `DEPTH`=16 for all scenarios.
- **Normal load**: send N=3, then words 0x00500093, 0x00100113, 0x002081B3 → `ram[0..2]` match; `core_reset` falls one cycle after the last stop-bit `byte_valid`; `words_loaded`=3; `pc`=8 gives `instr`=0x002081B3.
- **Empty program**: send N=0 → RUN after 4 bytes; `words_loaded`=0; `core_reset` low.
- **Overflow**: send N=18 with word i = i → `ram[0..15]` = 0..15; `words_loaded`=16; RUN only after all 72 data bytes; `pc`=0x40 wraps to `ram[0]`.
- **Framing error**: send 0x13 with stop bit 0 → `frame_err`=1, no `byte_valid`, lane counter unchanged; line held low for 20 cycles then released → next byte 0x55 received correctly.
- **Glitch**: 1-cycle low pulse on `uart_rx` → no `byte_valid`; receiver idle.
- **Reset mid-load**: assert `reset` after 2 of 3 words → `core_reset`=1, state WAIT_LEN, `words_loaded`=0, `ram[0..1]` retained; reload of N=1 word 0xDEADBEEF overwrites `ram[0]`.
